serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/serial_compare_ctrl_if.sv | 28 ++
 rtl/serial_compare_ctrl.sv | 113 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/serial_compare_ctrl_if.sv
// Handshake and result bundle for serial_compare_ctrl.
// The master drives the request and operands; the slave (the comparator)
// drives status and registered results.
interface serial_compare_ctrl_if #(
    parameter int N = 8
);
    localparam int IW = $clog2(N);

    logic          start;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          busy;
    logic          done;
    logic          a_eq_b;
    logic          b_gt_a;
    logic          a_gt_b;
    logic [IW-1:0] bit_idx;

    modport master (
        output start, a, b,
        input  busy, done, a_eq_b, b_gt_a, a_gt_b, bit_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_eq_b, b_gt_a, a_gt_b, bit_idx
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude comparator: walks one bit pair per cycle from the MSB
// of latched operands, stopping at the first differing bit, and registers
// equal / B-greater / A-greater flags that hold until the next comparison.
module serial_compare_ctrl #(
    parameter int N = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_compare_ctrl_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic          e_q, e_d;
    logic          g_q, g_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic          done_q, done_d;
    logic          a_eq_b_q, a_eq_b_d;
    logic          b_gt_a_q, b_gt_a_d;
    logic          a_gt_b_q, a_gt_b_d;
    logic          e_next, g_next;

    // Next-state, slice evaluation and result capture.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        e_d       = e_q;
        g_d       = g_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        a_eq_b_d  = a_eq_b_q;
        b_gt_a_d  = b_gt_a_q;
        a_gt_b_d  = a_gt_b_q;

        e_next = e_q & ~(a_q[bit_idx_q] ^ b_q[bit_idx_q]);
        g_next = g_q | (e_q & b_q[bit_idx_q] & ~a_q[bit_idx_q]);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a;
                    b_d       = bus.b;
                    e_d       = 1'b1;
                    g_d       = 1'b0;
                    bit_idx_d = IW'(N - 1);
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                e_d = e_next;
                g_d = g_next;
                if (bit_idx_q == '0 || !e_next) begin
                    // Index is parked at 0 on exit so it reads 0 outside SCAN.
                    bit_idx_d = '0;
                    a_eq_b_d  = e_next;
                    b_gt_a_d  = g_next;
                    a_gt_b_d  = ~e_next & ~g_next;
                    state_d   = DONE;
                end else begin
                    bit_idx_d = bit_idx_q - IW'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            e_q       <= 1'b1;
            g_q       <= 1'b0;
            bit_idx_q <= '0;
            done_q    <= 1'b0;
            a_eq_b_q  <= 1'b0;
            b_gt_a_q  <= 1'b0;
            a_gt_b_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            e_q       <= e_d;
            g_q       <= g_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
            a_eq_b_q  <= a_eq_b_d;
            b_gt_a_q  <= b_gt_a_d;
            a_gt_b_q  <= a_gt_b_d;
        end
    end

    assign bus.busy    = (state_q == SCAN);
    assign bus.done    = done_q;
    assign bus.a_eq_b  = a_eq_b_q;
    assign bus.b_gt_a  = b_gt_a_q;
    assign bus.a_gt_b  = a_gt_b_q;
    assign bus.bit_idx = bit_idx_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Scoreboard bench for serial_compare_ctrl (N=8): the driver pushes the
// expected result flags and the edge after which done must be seen; the
// monitor pops on every done pulse and compares.
module tb_serial_compare_ctrl;
    localparam int N = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_compare_ctrl_if #(.N(N)) bus();

    serial_compare_ctrl #(.N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // res = {a_eq_b, b_gt_a, a_gt_b}
    typedef struct {
        logic [2:0]  res;
        int unsigned at;
    } exp_t;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [2:0]  res;
        int unsigned k;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc     = 0;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    // Edge counter: at a negedge it equals the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result", 32'({bus.a_eq_b, bus.b_gt_a, bus.a_gt_b}), 32'(mon_e.res));
                check("onehot", 32'($countones({bus.a_eq_b, bus.b_gt_a, bus.a_gt_b})), 32'd1);
                check("latency_edge", cyc, mon_e.at);
            end
        end
    end

    task automatic wait_idle();
        int unsigned n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    // Called at a negedge with the DUT idle: start is accepted at edge cyc+1.
    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] res, input int unsigned k);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        sb.push_back(exp_t'{res: res, at: cyc + 1 + k + 1});
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        wait_idle();
    endtask

    function automatic int unsigned ref_k(input logic [7:0] a, input logic [7:0] b);
        for (int i = N - 1; i >= 0; i--)
            if (a[i] != b[i]) return N - i;
        return N;
    endfunction

    vec_t dir[8] = '{
        '{8'h5A, 8'h5A, 3'b100, 8},
        '{8'h80, 8'h7F, 3'b001, 1},
        '{8'h10, 8'h11, 3'b010, 8},
        '{8'h00, 8'hFF, 3'b010, 1},
        '{8'h3C, 8'h34, 3'b001, 5},
        '{8'h00, 8'h00, 3'b100, 8},
        '{8'hFF, 8'hFE, 3'b001, 8},
        '{8'h01, 8'h02, 3'b010, 7}
    };

    vec_t bb[4] = '{
        '{8'hA5, 8'hA5, 3'b100, 8},
        '{8'hF0, 8'h0F, 3'b001, 1},
        '{8'h12, 8'h13, 3'b010, 8},
        '{8'h40, 8'h60, 3'b010, 3}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned next_acc;
        int unsigned idx;
        logic [7:0]  ra, rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_bit_idx", 32'(bus.bit_idx), 32'd0);
        check("rst_results", 32'({bus.a_eq_b, bus.b_gt_a, bus.a_gt_b}), 32'd0);

        // Directed single comparisons; first one is issued in the first IDLE cycle.
        rst_n = 1'b1;
        foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].res, dir[i].k);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        check("hold_results", 32'({bus.a_eq_b, bus.b_gt_a, bus.a_gt_b}), 32'b010);

        // Start held high, operands scrambled on every non-accept cycle.
        next_acc  = cyc + 1;
        idx       = 0;
        bus.start = 1'b1;
        while (idx < 4) begin
            if (cyc + 1 == next_acc) begin
                bus.a = bb[idx].a;
                bus.b = bb[idx].b;
                sb.push_back(exp_t'{res: bb[idx].res, at: next_acc + bb[idx].k + 1});
                next_acc = next_acc + bb[idx].k + 2;
                idx++;
            end else begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_idle();

        // Reset while scanning bit 4 aborts without a done pulse.
        bus.a     = 8'h5A;
        bus.b     = 8'h5A;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_scan_bit_idx", 32'(bus.bit_idx), 32'd4);
        check("mid_scan_busy",    32'(bus.busy),    32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",    32'(bus.busy),    32'd0);
        check("abort_done",    32'(bus.done),    32'd0);
        check("abort_bit_idx", 32'(bus.bit_idx), 32'd0);
        check("abort_results", 32'({bus.a_eq_b, bus.b_gt_a, bus.a_gt_b}), 32'd0);
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        issue(8'h80, 8'h7F, 3'b001, 1);

        // Random operands against a behavioural reference.
        for (int n = 0; n < 300; n++) begin
            ra = 8'($urandom);
            rb = (n % 7 == 0) ? ra : 8'($urandom);
            issue(ra, rb, {ra == rb, rb > ra, ra > rb}, ref_k(ra, rb));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
